mcdf_arbiter: RTL and testbench
===============================

Name: mcdf_arbiter

Overview:
- Three-channel packet arbiter that sits between the per-channel slave FIFOs and the formatter.
- When the formatter requests a new channel ID, it picks one ready channel by programmable priority, with round-robin among equal priorities.
- Presents that channel's ID and package-length select, then streams exactly one packet of words into the formatter under the formatter's ack.
- Returns to arbitration after the last word of the packet.

Parameters:
- DATA_W, 32, word width on the slave and formatter data paths
- PRIO_W, 2, width of each channel priority field (lower value = higher priority)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  channel holds at least one full packet
- slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  channel FIFO head word valid (FIFO not empty)
- slv0_data_i / slv1_data_i / slv2_data_i  in  DATA_W each  channel FIFO head word
- slv0_ack_o / slv1_ack_o / slv2_ack_o  out  1 each  pop the channel FIFO head this cycle
- slv0_en_i / slv1_en_i / slv2_en_i  in  1 each  channel enable from register block
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  PRIO_W each  channel priority
- slv0_pkglen_i / slv1_pkglen_i / slv2_pkglen_i  in  3 each  channel package-length select
- fmt_id_req_i  in  1  formatter ready to accept a new packet
- f2a_ack_i  in  1  formatter consumed the current word
- a2f_val_o  out  1  word valid to formatter
- a2f_id_o  out  2  granted channel ID
- a2f_data_o  out  DATA_W  word to formatter
- pkglen_sel_o  out  3  package-length select of the granted channel

Behaviour:
- Reset (async, rstn_i low):
  - state=IDLE; a2f_id_o=0; pkglen_sel_o=0; a2f_val_o=0; all slvN_ack_o=0; word counter=0; round-robin pointer=0.
  - Reset asserted mid-packet aborts the packet immediately; no partial state survives.
- States:
  - IDLE: eligible = slvN_req_i & slvN_en_i.
    - If fmt_id_req_i=1 and any channel is eligible, register the winner into a2f_id_o and its slvN_pkglen_i into pkglen_sel_o, clear the counter, and go to XFER on the next edge (1-cycle grant latency).
    - Otherwise stay in IDLE.
  - XFER:
    - Outputs:
      - a2f_val_o = slvK_val_i of the granted channel K, combinational.
      - a2f_data_o = slvK_data_i, combinational.
      - slvK_ack_o = f2a_ack_i & a2f_val_o; slv_ack_o of the other channels = 0.
    - On each f2a_ack_i & a2f_val_o, increment the counter.
    - When the ack hits the last word (counter = N-1), return to IDLE on the same edge.
- Package length N is decoded from the latched pkglen_sel_o: 0→4, 1→8, 2→16, 3→32, 4..7→32. The counter is 6 bits.
- Arbitration:
  - Lowest prio value wins.
  - Among equal lowest values, start searching at the RR pointer: channel order ptr, ptr+1, ptr+2 mod 3.
  - After each grant, the pointer becomes (granted ID + 1) mod 3.
  - Channels with prio equal to all others therefore rotate 0→1→2→0.
- Boundary rules:
  - Outside XFER: a2f_val_o=0 and a2f_data_o=0.
  - f2a_ack_i while a2f_val_o=0 is ignored: no pop, no count.
  - FIFO underrun mid-packet (slvK_val_i=0) stalls the packet; the arbiter never switches channel mid-packet.
  - slvK_req_i or slvK_en_i dropping during XFER does not abort; the packet completes.
  - slvN_prio_i / slvN_pkglen_i changes during XFER take effect only at the next grant; pkglen_sel_o is stable for the whole packet.
  - fmt_id_req_i is ignored in XFER.
  - A new grant needs at least 1 IDLE cycle after the last word.
  - No eligible channel while fmt_id_req_i=1: stay in IDLE, all outputs at idle values.
  - Simultaneous last-word ack and new req: the new req is evaluated in the following IDLE cycle.
- a2f_id_o holds its last value in IDLE.

Test Plan:
- All prio=0, all req/en/val=1, pkglen_sel=0, fmt_id_req and f2a_ack held high → grants 0,1,2,0 in order; each packet is 4 words; pkglen_sel_o=0; exactly 4 acks per slave per grant.
- prio {2,1,0}, all ready → ch2 granted repeatedly; after setting ch2 en=0 → ch1 granted; ch0 never granted while ch1 is ready.
- ch1 only, pkglen_sel=3, slv1_val_i toggled low for 5 cycles mid-packet → a2f_val_o=0 during the gap, no slv1_ack_o; exactly 32 acked words in total, then IDLE.
- ch0 pkglen_sel=7, and pkglen changed to 0 mid-packet → packet stays 32 words; the next grant uses 4 words.
- rstn_i pulsed low at word 5 of a 16-word packet → all outputs return to reset values asynchronously; after release, the first grant goes to the winner from ptr=0.
- fmt_id_req_i=0 with all channels ready for 10 cycles → no grant and no acks; the grant appears 1 cycle after fmt_id_req_i rises.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// Purpose: three-channel packet arbiter between the slave FIFOs and the formatter.
//          It grants one channel by priority (ties broken round-robin), then streams one packet of words.
// Latency: the grant registers one cycle after fmt_id_req_i; the data path is combinational from the granted slave.
// Backpressure: a word moves only when a2f_val_o & f2a_ack_i. A slave underrun stalls the packet in place.
//
// Ports:
//   clk_i, rstn_i                    clock, async active-low reset
//   slvN_req/val/data/en/prio/pkglen slave FIFO status, head word and per-channel configuration
//   slvN_ack_o                       pop strobe to the granted slave FIFO
//   fmt_id_req_i, f2a_ack_i          formatter asks for a new packet / consumed the current word
//   a2f_val_o, a2f_id_o, a2f_data_o  word valid, granted channel ID and word to the formatter
//   pkglen_sel_o                     package-length select latched at grant
module mcdf_arbiter #(
  parameter int DATA_W = 32,
  parameter int PRIO_W = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              slv0_req_i,
  input  logic              slv1_req_i,
  input  logic              slv2_req_i,
  input  logic              slv0_val_i,
  input  logic              slv1_val_i,
  input  logic              slv2_val_i,
  input  logic [DATA_W-1:0] slv0_data_i,
  input  logic [DATA_W-1:0] slv1_data_i,
  input  logic [DATA_W-1:0] slv2_data_i,
  output logic              slv0_ack_o,
  output logic              slv1_ack_o,
  output logic              slv2_ack_o,
  input  logic              slv0_en_i,
  input  logic              slv1_en_i,
  input  logic              slv2_en_i,
  input  logic [PRIO_W-1:0] slv0_prio_i,
  input  logic [PRIO_W-1:0] slv1_prio_i,
  input  logic [PRIO_W-1:0] slv2_prio_i,
  input  logic [2:0]        slv0_pkglen_i,
  input  logic [2:0]        slv1_pkglen_i,
  input  logic [2:0]        slv2_pkglen_i,
  input  logic              fmt_id_req_i,
  input  logic              f2a_ack_i,
  output logic              a2f_val_o,
  output logic [1:0]        a2f_id_o,
  output logic [DATA_W-1:0] a2f_data_o,
  output logic [2:0]        pkglen_sel_o
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  id_q;
  logic [2:0]  pkglen_q;
  logic [5:0]  word_cnt;
  logic [1:0]  rr_ptr;

  // Per-channel views of the flat ports so the arbitration can loop over channels.
  logic [2:0]        req;
  logic [2:0]        en;
  logic [2:0]        elig;
  logic [PRIO_W-1:0] prio [3];
  logic [2:0]        pkglen [3];

  assign req     = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign en      = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign elig    = req & en;
  assign prio[0] = slv0_prio_i;
  assign prio[1] = slv1_prio_i;
  assign prio[2] = slv2_prio_i;
  assign pkglen[0] = slv0_pkglen_i;
  assign pkglen[1] = slv1_pkglen_i;
  assign pkglen[2] = slv2_pkglen_i;

  // Index of the last word of a packet for a given length select.
  function automatic logic [5:0] last_word(input logic [2:0] sel);
    case (sel)
      3'd0:    last_word = 6'd3;
      3'd1:    last_word = 6'd7;
      3'd2:    last_word = 6'd15;
      default: last_word = 6'd31;
    endcase
  endfunction

  // Arbitration: first find the lowest priority value among eligible channels,
  // then take the first channel with that value scanning from the RR pointer.
  logic              any_elig;
  logic [PRIO_W-1:0] min_prio;
  logic [1:0]        win;
  logic              found;
  logic [2:0]        scan_sum;
  logic [1:0]        scan_idx;

  always_comb begin
    any_elig = 1'b0;
    min_prio = '1;
    win      = 2'd0;
    found    = 1'b0;
    scan_sum = 3'd0;
    scan_idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (!any_elig || prio[i] < min_prio)) begin
        min_prio = prio[i];
        any_elig = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      scan_sum = {1'b0, rr_ptr} + 3'(k);
      scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
      if (!found && elig[scan_idx] && prio[scan_idx] == min_prio) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Head word of the granted channel.
  logic              cur_val;
  logic [DATA_W-1:0] cur_data;

  always_comb begin
    cur_val  = 1'b0;
    cur_data = '0;
    case (id_q)
      2'd0: begin
        cur_val  = slv0_val_i;
        cur_data = slv0_data_i;
      end
      2'd1: begin
        cur_val  = slv1_val_i;
        cur_data = slv1_data_i;
      end
      2'd2: begin
        cur_val  = slv2_val_i;
        cur_data = slv2_data_i;
      end
      default: begin
        cur_val  = 1'b0;
        cur_data = '0;
      end
    endcase
  end

  logic in_xfer;
  logic beat;

  assign in_xfer = (state == XFER);
  // An ack against an empty head is not a transfer: no pop and no count.
  assign beat    = in_xfer & cur_val & f2a_ack_i;

  assign a2f_val_o    = in_xfer & cur_val;
  assign a2f_data_o   = in_xfer ? cur_data : '0;
  assign a2f_id_o     = id_q;
  assign pkglen_sel_o = pkglen_q;

  assign slv0_ack_o = beat & (id_q == 2'd0);
  assign slv1_ack_o = beat & (id_q == 2'd1);
  assign slv2_ack_o = beat & (id_q == 2'd2);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      id_q     <= 2'd0;
      pkglen_q <= 3'd0;
      word_cnt <= 6'd0;
      rr_ptr   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fmt_id_req_i && any_elig) begin
            id_q     <= win;
            pkglen_q <= pkglen[win];
            word_cnt <= 6'd0;
            rr_ptr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            state    <= XFER;
          end
        end
        XFER: begin
          // Length comes from the latched select, so mid-packet config changes cannot alter it.
          if (beat) begin
            if (word_cnt == last_word(pkglen_q)) begin
              word_cnt <= 6'd0;
              state    <= IDLE;
            end else begin
              word_cnt <= word_cnt + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: a table of per-packet grant vectors followed
// by hand sequences for request gating, FIFO underrun, mid-packet length change
// and asynchronous reset during a packet.
module tb_mcdf_arbiter;
  localparam int DATA_W = 32;
  localparam int PRIO_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [2:0]        req, en, val;
  logic [DATA_W-1:0] dat [3];
  logic [PRIO_W-1:0] prio [3];
  logic [2:0]        pl [3];
  logic              fmt_id_req, f2a_ack;
  wire  [2:0]        ack;
  logic              a2f_val;
  logic [1:0]        a2f_id;
  logic [DATA_W-1:0] a2f_data;
  logic [2:0]        pkglen_sel;

  int total  = 0;
  int passed = 0;

  mcdf_arbiter #(.DATA_W(DATA_W), .PRIO_W(PRIO_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
    .slv0_val_i(val[0]), .slv1_val_i(val[1]), .slv2_val_i(val[2]),
    .slv0_data_i(dat[0]), .slv1_data_i(dat[1]), .slv2_data_i(dat[2]),
    .slv0_ack_o(ack[0]), .slv1_ack_o(ack[1]), .slv2_ack_o(ack[2]),
    .slv0_en_i(en[0]), .slv1_en_i(en[1]), .slv2_en_i(en[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .slv0_pkglen_i(pl[0]), .slv1_pkglen_i(pl[1]), .slv2_pkglen_i(pl[2]),
    .fmt_id_req_i(fmt_id_req), .f2a_ack_i(f2a_ack),
    .a2f_val_o(a2f_val), .a2f_id_o(a2f_id), .a2f_data_o(a2f_data),
    .pkglen_sel_o(pkglen_sel)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] en;
    logic [1:0] p0, p1, p2;
    logic [2:0] l0, l1, l2;
    int         exp_id;
    int         exp_pl;
    int         exp_len;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Requests a packet, expects the given grant, acks every word and counts pops.
  // gap_at/gap_len: drop the granted channel's val for gap_len cycles starting at beat slot gap_at.
  // chg_at/chg_pl: rewrite the granted channel's pkglen input at slot chg_at.
  task automatic run_packet(input string tag, input int exp_id, input int exp_pl, input int exp_len,
                            input int gap_at, input int gap_len, input int chg_at, input logic [2:0] chg_pl,
                            output int lat);
    int words, wrong, bad;
    bit done;
    fmt_id_req = 1'b1;
    f2a_ack    = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!a2f_val && lat < 20);
    chk({tag, " grant"}, a2f_val, 1);
    if (!a2f_val) begin
      fmt_id_req = 1'b0;
      return;
    end
    chk({tag, " id"}, a2f_id, exp_id);
    chk({tag, " pkglen_sel"}, pkglen_sel, exp_pl);
    chk({tag, " data"}, a2f_data, dat[exp_id]);
    // fmt_id_req stays high through the packet: it must be ignored in XFER and
    // must not produce a grant on the edge of the last word.
    f2a_ack = 1'b1;
    words = 0; wrong = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c == chg_at) pl[exp_id] = chg_pl;
      val[exp_id] = !(c >= gap_at && c < gap_at + gap_len);
      #1;
      if (pkglen_sel != 3'(exp_pl)) bad++;
      if (!val[exp_id]) begin
        if (a2f_val || ack != 3'b000) bad++;
      end else if (!a2f_val) begin
        done = 1'b1;
        break;
      end else begin
        for (int k = 0; k < 3; k++)
          if (ack[k]) begin
            if (k == exp_id) words++;
            else wrong++;
          end
      end
      @(negedge clk); #1;
    end
    fmt_id_req  = 1'b0;
    f2a_ack     = 1'b0;
    val[exp_id] = 1'b1;
    chk({tag, " returned to idle"}, done, 1);
    chk({tag, " words"}, words, exp_len);
    chk({tag, " foreign acks"}, wrong, 0);
    chk({tag, " stall/pkglen violations"}, bad, 0);
    chk({tag, " idle data"}, a2f_data, 0);
    chk({tag, " id held"}, a2f_id, exp_id);
  endtask

  initial begin
    int lat, idle_bad, n;
    //            req     en      p0 p1 p2 l0 l1 l2 id pl len
    tbl[0]  = '{3'b111, 3'b111, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0, 4};
    tbl[1]  = '{3'b111, 3'b111, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1, 0, 4};
    tbl[2]  = '{3'b111, 3'b111, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2, 0, 4};
    tbl[3]  = '{3'b111, 3'b111, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0, 4};
    tbl[4]  = '{3'b111, 3'b111, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 2, 0, 4};
    tbl[5]  = '{3'b111, 3'b111, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 2, 0, 4};
    tbl[6]  = '{3'b111, 3'b011, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 1, 0, 4};
    tbl[7]  = '{3'b111, 3'b011, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 1, 0, 4};
    tbl[8]  = '{3'b110, 3'b011, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1, 3'd0, 1, 1, 8};
    tbl[9]  = '{3'b111, 3'b111, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 2, 2, 16};
    tbl[10] = '{3'b111, 3'b111, 2'd1, 2'd0, 2'd0, 3'd0, 3'd3, 3'd2, 1, 3, 32};
    tbl[11] = '{3'b111, 3'b111, 2'd0, 2'd3, 2'd3, 3'd5, 3'd3, 3'd2, 0, 5, 32};
    tbl[12] = '{3'b111, 3'b111, 2'd3, 2'd3, 2'd3, 3'd4, 3'd4, 3'd4, 1, 4, 32};

    dat[0] = 32'h1111_00A0;
    dat[1] = 32'h2222_00B1;
    dat[2] = 32'h3333_00C2;
    rstn = 1'b0; req = 3'b111; en = 3'b111; val = 3'b111;
    for (int i = 0; i < 3; i++) begin
      prio[i] = 2'd0;
      pl[i]   = 3'd0;
    end
    fmt_id_req = 1'b1; f2a_ack = 1'b1;

    #12;
    chk("reset a2f_val", a2f_val, 0);
    chk("reset acks", ack, 0);
    chk("reset id", a2f_id, 0);
    chk("reset pkglen_sel", pkglen_sel, 0);
    chk("reset data", a2f_data, 0);
    fmt_id_req = 1'b0; f2a_ack = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; en = tbl[i].en;
      prio[0] = tbl[i].p0; prio[1] = tbl[i].p1; prio[2] = tbl[i].p2;
      pl[0] = tbl[i].l0; pl[1] = tbl[i].l1; pl[2] = tbl[i].l2;
      run_packet($sformatf("vec%0d", i), tbl[i].exp_id, tbl[i].exp_pl, tbl[i].exp_len,
                 -1, 0, -1, 3'd0, lat);
    end

    // No request from the formatter: nothing moves; grant one cycle after it rises.
    req = 3'b111; en = 3'b111;
    for (int i = 0; i < 3; i++) begin
      prio[i] = 2'd0;
      pl[i]   = 3'd0;
    end
    fmt_id_req = 1'b0; f2a_ack = 1'b1;
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (a2f_val || ack != 3'b000) idle_bad++;
    end
    chk("no fmt_id_req idle activity", idle_bad, 0);
    run_packet("fmtreq", 2, 0, 4, -1, 0, -1, 3'd0, lat);
    chk("fmtreq grant latency", lat, 1);

    // Underrun: channel 1 alone, 32-word packet, val low for 5 cycles mid-packet.
    req = 3'b010; pl[1] = 3'd3;
    run_packet("underrun", 1, 3, 32, 10, 5, -1, 3'd0, lat);

    // pkglen change mid-packet must not alter the packet in flight.
    req = 3'b001; pl[0] = 3'd7;
    run_packet("pkglen_chg", 0, 7, 32, -1, 0, 8, 3'd0, lat);
    run_packet("pkglen_next", 0, 0, 4, -1, 0, -1, 3'd0, lat);

    // Asynchronous reset in the middle of a 16-word packet on channel 1.
    req = 3'b111; prio[0] = 2'd1; prio[1] = 2'd0; prio[2] = 2'd1; pl[1] = 3'd2;
    fmt_id_req = 1'b1; f2a_ack = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!a2f_val && n < 20);
    chk("rst_mid grant id", a2f_id, 1);
    chk("rst_mid pkglen_sel", pkglen_sel, 2);
    f2a_ack = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    chk("rst_mid a2f_val", a2f_val, 0);
    chk("rst_mid acks", ack, 0);
    chk("rst_mid id", a2f_id, 0);
    chk("rst_mid pkglen_sel", pkglen_sel, 0);
    chk("rst_mid data", a2f_data, 0);
    fmt_id_req = 1'b0; f2a_ack = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // Pointer restarted at 0, so channel 0 wins the three-way tie.
    for (int i = 0; i < 3; i++) prio[i] = 2'd0;
    run_packet("post_reset", 0, 0, 4, -1, 0, -1, 3'd0, lat);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
